// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8E1 UART receiver with 2-flop rx synchronizer; define UART_RX_PARITY_CHECK_EN to enable parity checking
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 5210,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [2:0] rx_state
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic          tick, perr_calc;

    assign tick = cnt_q == BIT_LAST;

`ifdef UART_RX_PARITY_CHECK_EN
    logic par_q, par_d;
    assign par_d     = (state_q == PARITY && tick) ? sync2_q : par_q;
    assign perr_calc = par_q ^ (^shift_q);
    always_ff @(posedge clk) par_q <= rst ? 1'b0 : par_d;
`else
    assign perr_calc = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q inside {START, DATA, PARITY, STOP}) ? cnt_q + 1'b1 : '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE:    state_d = (prev_q && !sync2_q) ? START : IDLE;
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = (bit_q == 4'd7) ? 4'd0 : bit_q + 4'd1;
                    state_d = (bit_q == 4'd7) ? PARITY : DATA;
                end
            end
            PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    perr_d  = perr_calc;
                    ferr_d  = !sync2_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign rx_state   = state_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: scoreboard bench for uart_rx_frame with a frame-level reference model
module tb_uart_rx_frame;
    localparam int CPB  = 16;
    localparam int HALF = 8;
`ifdef UART_RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err;
    logic [2:0] rx_state;

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err), .rx_state(rx_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0, last_valid_cyc = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic p, input logic s);
        exp_t e;
        e.d  = d;
        e.pe = PCHK ? (p != ^d) : 1'b0;
        e.fe = !s;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && rx_valid) begin
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rx_data %0h, expected no frame", rx_data);
            end else begin
                e = sb.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e.d));
                chk("parity_err", 32'(parity_err), 32'(e.pe));
                chk("frame_err", 32'(frame_err), 32'(e.fe));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic p, input logic s, input int nbits, input int gap);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic p, input logic s, input int gap);
        sb.push_back(model(d, p, s));
        send(d, p, s, 11, gap);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_data"}, 32'(rx_data), 0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
        chk({tag, "_parity_err"}, 32'(parity_err), 0);
        chk({tag, "_frame_err"}, 32'(frame_err), 0);
        chk({tag, "_rx_state"}, 32'(rx_state), 0);
    endtask

    initial begin
        int t0, diff, lat;
        logic [7:0] d;
        logic p, s;
        repeat (4) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        t0 = cyc;
        frame(8'hA5, 1'b0, 1'b1, 10);
        diff = last_valid_cyc - t0;
        lat  = HALF + 10 * CPB + 2;
        checks++;
        if (diff < lat - 2 || diff > lat + 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d +/-2", diff, lat);
        end

        frame(8'h01, 1'b0, 1'b1, 10);
        frame(8'h3C, 1'b0, 1'b0, 10);

        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_in_start", 32'(rx_state), 1);
        repeat (HALF + 4) @(negedge clk);
        chk("glitch_back_idle", 32'(rx_state), 0);
        repeat (CPB) @(negedge clk);

        frame(8'h55, 1'b0, 1'b1, 0);
        frame(8'hAA, 1'b0, 1'b1, 10);

        frame(8'h00, 1'b0, 1'b0, 0);
        repeat (5 * CPB) @(negedge clk);
        chk("break_idle", 32'(rx_state), 0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~^d : ^d;
            s = $urandom_range(0, 7) != 0;
            frame(d, p, s, s ? $urandom_range(0, 40) : $urandom_range(2, 40));
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        send(8'h7E, 1'b0, 1'b1, 6, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midframe_reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        frame(8'h7E, 1'b0, 1'b1, 10);

        repeat (2 * CPB) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
